// File: rtl/frame_scheduler_pkg.sv
// Shared types and defaults for the frame scheduler.
// Holds the FSM state encoding, the raster defaults and the pixel field widths.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CLEAR  = 2'b01,
    DRAW   = 2'b10,
    UPDATE = 2'b11
  } state_e;

  localparam int COLOR_W      = 3;
  localparam int COORD_W      = 10;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam logic [COLOR_W-1:0] DEF_BG_COLOR = 3'b000;

endpackage

// File: rtl/frame_scheduler_if.sv
// Pixel write bus (x, y, colour, plot).
// Used both for the draw controller's stream into the scheduler and for the VGA write port.
interface frame_scheduler_if;
  import frame_sched_pkg::*;

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COLOR_W-1:0] color;
  logic               plot;

  modport master (output x, y, color, plot);
  modport slave  (input  x, y, color, plot);
endinterface

// File: rtl/frame_scheduler_clear_engine.sv
// Raster counter for the clear sweep.
// start zeroes the counters, en advances them, last flags (SCREEN_W-1, SCREEN_H-1).
module clear_engine
  import frame_sched_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               en,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);
  localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;

  logic [XW-1:0] xc;
  logic [YW-1:0] yc;
  logic          x_end, y_end;

  assign x_end = (xc == XW'(SCREEN_W - 1));
  assign y_end = (yc == YW'(SCREEN_H - 1));
  assign last  = x_end & y_end;
  assign cx    = COORD_W'(xc);
  assign cy    = COORD_W'(yc);

  // The counter wraps back to (0,0) after the last pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xc <= '0;
      yc <= '0;
    end else if (start) begin
      xc <= '0;
      yc <= '0;
    end else if (en) begin
      if (x_end) begin
        xc <= '0;
        yc <= y_end ? '0 : yc + 1'b1;
      end else begin
        xc <= xc + 1'b1;
      end
    end
  end
endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: clear sweep, draw pass, then game-logic update.
// Owns the VGA pixel write port; every output is a flop.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int                 SCREEN_W     = DEF_SCREEN_W,
  parameter int                 SCREEN_H     = DEF_SCREEN_H,
  parameter logic [COLOR_W-1:0] BG_COLOR     = DEF_BG_COLOR,
  parameter int                 DRAW_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  output logic                draw_start,
  input  logic                draw_done,
  frame_scheduler_if.slave    d,
  output logic                update_req,
  input  logic                update_ack,
  frame_scheduler_if.master   vga,
  output logic                busy,
  output logic [7:0]          overrun_count,
  output logic                timeout_flag,
  output logic [1:0]          state
);
  localparam int TW = $clog2(DRAW_TIMEOUT + 1);

  state_e             cur, nxt;
  logic [TW-1:0]      tcnt;
  logic               done_q;
  logic               clr_last;
  logic [COORD_W-1:0] cx, cy;
  logic               rise, tmo, draw_exit;

  // The cycle carrying draw_start is excluded so a level already high at entry cannot end the pass.
  assign rise      = draw_done & ~done_q & ~draw_start;
  assign tmo       = (tcnt == TW'(DRAW_TIMEOUT - 1));
  assign draw_exit = rise | tmo;

  clear_engine #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_clear (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (cur == IDLE && frame_tick),
    .en      (cur == CLEAR),
    .cx      (cx),
    .cy      (cy),
    .last    (clr_last)
  );

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (frame_tick) nxt = CLEAR;
      CLEAR:   if (clr_last)   nxt = DRAW;
      DRAW:    if (draw_exit)  nxt = UPDATE;
      UPDATE:  if (update_ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur           <= IDLE;
      state         <= 2'b00;
      busy          <= 1'b0;
      draw_start    <= 1'b0;
      done_q        <= 1'b0;
      tcnt          <= '0;
      timeout_flag  <= 1'b0;
      overrun_count <= 8'd0;
      update_req    <= 1'b0;
      vga.x         <= '0;
      vga.y         <= '0;
      vga.color     <= '0;
      vga.plot      <= 1'b0;
    end else begin
      cur        <= nxt;
      state      <= nxt;
      busy       <= (nxt != IDLE);
      draw_start <= (cur == CLEAR) && clr_last;
      done_q     <= draw_done;
      tcnt       <= (cur == DRAW) ? tcnt + 1'b1 : '0;
      update_req <= (nxt == UPDATE);
      if (cur == DRAW && tmo) timeout_flag <= 1'b1;
      // Ticks outside IDLE are dropped, never queued.
      if (frame_tick && cur != IDLE && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
      case (cur)
        CLEAR: begin
          vga.x     <= cx;
          vga.y     <= cy;
          vga.color <= BG_COLOR;
          vga.plot  <= 1'b1;
        end
        DRAW: begin
          if (draw_exit) begin
            vga.plot <= 1'b0;
          end else begin
            vga.x     <= d.x;
            vga.y     <= d.y;
            vga.color <= d.color;
            vga.plot  <= d.plot;
          end
        end
        default: vga.plot <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler on a 4x2 raster with a 16-cycle draw timeout.
// Expected pixels go into a queue when stimulus is driven; a monitor pops them on every plot.
module tb_frame_scheduler;
  import frame_sched_pkg::*;

  localparam int W = 4;
  localparam int H = 2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick, draw_done, update_ack;
  logic       draw_start, update_req, busy, timeout_flag;
  logic [7:0] overrun_count;
  logic [1:0] state;

  frame_scheduler_if drw ();
  frame_scheduler_if vga ();

  frame_scheduler #(
    .SCREEN_W(W), .SCREEN_H(H), .BG_COLOR(3'b000), .DRAW_TIMEOUT(16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .draw_start    (draw_start),
    .draw_done     (draw_done),
    .d             (drw),
    .update_req    (update_req),
    .update_ack    (update_ack),
    .vga           (vga),
    .busy          (busy),
    .overrun_count (overrun_count),
    .timeout_flag  (timeout_flag),
    .state         (state)
  );

  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   ds_count = 0;
  pix_t sb[$];

  // Monitor runs on the falling edge, before the directed steps sample at negedge+1.
  always @(negedge clk) begin
    pix_t got, exp;
    if (draw_start) ds_count++;
    if (vga.plot) begin
      got = '{vga.x, vga.y, vga.color};
      exp = (sb.size() != 0) ? sb.pop_front() : '1;
      n_assert++;
      assert (got === exp) else begin
        n_fail++;
        $error("FAIL pixel: observed x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
               got.x, got.y, got.c, exp.x, exp.y, exp.c);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_clear();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        sb.push_back('{10'(xx), 10'(yy), 3'b000});
  endtask

  task automatic wait_ds(input string tag);
    int n = 0;
    while (!draw_start && n < 64) begin
      step();
      n++;
    end
    chk({tag, "_draw_start"}, 32'(draw_start), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; draw_done = 1'b0; update_ack = 1'b0;
    drw.x = '0; drw.y = '0; drw.color = '0; drw.plot = 1'b0;
    step(); step();
    chk("rst_state",   32'(state), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_plot",    32'(vga.plot), 0);
    chk("rst_overrun", 32'(overrun_count), 0);
    chk("rst_tmo",     32'(timeout_flag), 0);
    chk("rst_ureq",    32'(update_req), 0);
    chk("rst_dstart",  32'(draw_start), 0);
    reset_n = 1'b1;
    step();

    // Frame 1: clear sweep, forwarding, draw_done rise, slow ack
    frame_tick = 1'b1; push_clear(); step(); frame_tick = 1'b0;
    chk("enter_clear",   32'(state), 1);
    chk("busy_clear",    32'(busy), 1);
    chk("no_plot_entry", 32'(vga.plot), 0);
    wait_ds("f1");
    chk("f1_clear_done", 32'(sb.size()), 0);
    chk("f1_draw_state", 32'(state), 2);
    drw.x = 10'd37; drw.y = 10'd12; drw.color = 3'd5; drw.plot = 1'b1;
    sb.push_back('{10'd37, 10'd12, 3'd5});
    step(); drw.plot = 1'b0;
    chk("ds_one_pulse", 32'(draw_start), 0);
    chk("fwd_x",        32'(vga.x), 37);
    chk("fwd_color",    32'(vga.color), 5);
    draw_done = 1'b1;
    step();
    chk("rise_update", 32'(state), 3);
    chk("rise_ureq",   32'(update_req), 1);
    chk("update_plot", 32'(vga.plot), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ureq_hold", 32'(update_req), 1);
    end
    update_ack = 1'b1; step(); update_ack = 1'b0;
    chk("ack_idle", 32'(state), 0);
    chk("ack_ureq", 32'(update_req), 0);
    chk("ack_busy", 32'(busy), 0);

    // Frame 2: tick right after return to IDLE; draw_done already high at entry
    frame_tick = 1'b1; push_clear(); step(); frame_tick = 1'b0;
    chk("f2_accept",      32'(state), 1);
    chk("f2_no_overrun",  32'(overrun_count), 0);
    wait_ds("f2");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("level_no_exit", 32'(state), 2);
    end
    draw_done = 1'b0; step();
    chk("fall_no_exit", 32'(state), 2);
    draw_done = 1'b1; step();
    chk("rerise_exit", 32'(state), 3);
    chk("f2_no_tmo",   32'(timeout_flag), 0);
    update_ack = 1'b1; step(); update_ack = 1'b0; draw_done = 1'b0;
    chk("f2_idle", 32'(state), 0);

    // Frame 3: no draw_done, DRAW must last exactly 16 cycles
    frame_tick = 1'b1; push_clear(); step(); frame_tick = 1'b0;
    wait_ds("f3");
    for (int i = 0; i < 15; i++) begin
      step();
      chk("tmo_still_draw", 32'(state), 2);
    end
    chk("tmo_flag_before", 32'(timeout_flag), 0);
    step();
    chk("tmo_update", 32'(state), 3);
    chk("tmo_flag",   32'(timeout_flag), 1);
    chk("tmo_ureq",   32'(update_req), 1);

    // Overrun saturation while parked in UPDATE
    for (int i = 0; i < 300; i++) begin
      frame_tick = 1'b1;
      step();
      if (i == 9) chk("overrun_10", 32'(overrun_count), 10);
    end
    frame_tick = 1'b0;
    chk("overrun_sat",   32'(overrun_count), 255);
    chk("overrun_state", 32'(state), 3);
    update_ack = 1'b1; step(); update_ack = 1'b0;
    chk("f3_idle", 32'(state), 0);

    // Frame 4: accepted after saturation, then reset mid-clear
    frame_tick = 1'b1; push_clear(); step(); frame_tick = 1'b0;
    chk("idle_tick_after_sat", 32'(state), 1);
    chk("overrun_hold",        32'(overrun_count), 255);
    step(); step();
    reset_n = 1'b0;
    #1;
    chk("async_state",   32'(state), 0);
    chk("async_plot",    32'(vga.plot), 0);
    chk("async_x",       32'(vga.x), 0);
    chk("async_busy",    32'(busy), 0);
    chk("async_overrun", 32'(overrun_count), 0);
    chk("async_tmo",     32'(timeout_flag), 0);
    sb.delete();
    step(); step();
    reset_n = 1'b1;
    step();

    // Frame 5: clear restarts at (0,0)
    frame_tick = 1'b1; push_clear(); step(); frame_tick = 1'b0;
    wait_ds("f5");
    chk("f5_clear_done", 32'(sb.size()), 0);
    chk("ds_count",      32'(ds_count), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
